// File: rtl/sys_cmd_pkg.sv
// sys_cmd_pkg: command codes, frame/response lengths and FSM states
// shared by sys_cmd_master and its helpers.
package sys_cmd_pkg;

    typedef enum logic [7:0] {
        CMD_WR      = 8'hAA,
        CMD_RD      = 8'hBB,
        CMD_ALU_OP  = 8'hCC,
        CMD_ALU_NOP = 8'hDD
    } e_CMD;

    localparam logic [2:0] FRM_LEN_WR      = 3'd3;
    localparam logic [2:0] FRM_LEN_RD      = 3'd2;
    localparam logic [2:0] FRM_LEN_ALU_OP  = 3'd4;
    localparam logic [2:0] FRM_LEN_ALU_NOP = 3'd2;

    localparam logic [1:0] RSP_LEN_WR      = 2'd0;
    localparam logic [1:0] RSP_LEN_RD      = 2'd1;
    localparam logic [1:0] RSP_LEN_ALU_OP  = 2'd2;
    localparam logic [1:0] RSP_LEN_ALU_NOP = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_DONE
    } e_STATE;

    function automatic logic is_legal(input logic [7:0] c);
        return (c == CMD_WR) || (c == CMD_RD) ||
               (c == CMD_ALU_OP) || (c == CMD_ALU_NOP);
    endfunction

    function automatic logic [2:0] frame_len(input logic [7:0] c);
        logic [2:0] n;
        n = 3'd0;
        unique case (1'b1)
            (c == CMD_WR):      n = FRM_LEN_WR;
            (c == CMD_RD):      n = FRM_LEN_RD;
            (c == CMD_ALU_OP):  n = FRM_LEN_ALU_OP;
            (c == CMD_ALU_NOP): n = FRM_LEN_ALU_NOP;
            default:            n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] rsp_len(input logic [7:0] c);
        logic [1:0] n;
        n = 2'd0;
        unique case (1'b1)
            (c == CMD_WR):      n = RSP_LEN_WR;
            (c == CMD_RD):      n = RSP_LEN_RD;
            (c == CMD_ALU_OP):  n = RSP_LEN_ALU_OP;
            (c == CMD_ALU_NOP): n = RSP_LEN_ALU_NOP;
            default:            n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rsp_timeout_cnt.sv
// rsp_timeout_cnt: response wait counter. clr zeroes it, run advances it,
// expired flags TIMEOUT_CYCLES-1 reached while running with no clear.
module rsp_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && !clr && (cnt == LAST);

endmodule

// File: rtl/sys_cmd_master.sv
// sys_cmd_master: serialises one RF/ALU request into UART command bytes
// and assembles the controller's reply into RSP_DATA/RSP_VLD/RSP_ERR.
// Ports: REQ_* request handshake, TX_* byte out, RX_* byte in, RSP_*, BUSY.
// Option: CMD_RSP_TIMEOUT_EN adds a response timeout (TIMEOUT_CYCLES).
module sys_cmd_master
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    REF_CLK,
    input  logic                    RST,
    input  logic                    REQ_VLD,
    output logic                    REQ_RDY,
    input  logic [7:0]              REQ_CMD,
    input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [7:0]              REQ_OPA,
    input  logic [7:0]              REQ_OPB,
    input  logic [3:0]              REQ_FUN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    input  logic                    TX_RDY,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_VLD,
    output logic                    RSP_ERR,
    output logic                    BUSY
);

    e_STATE                state;
    logic [7:0]            cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            opa_q;
    logic [7:0]            opb_q;
    logic [3:0]            fun_q;
    logic [1:0]            idx_q;
    logic [1:0]            idx_n;
    logic                  last_byte;
    logic [DATA_WIDTH-1:0] nxt_byte;
    logic [DATA_WIDTH-1:0] fun_b;

    assign idx_n     = idx_q + 2'd1;
    assign last_byte = ({1'b0, idx_q} == (frame_len(cmd_q) - 3'd1));
    assign fun_b     = {{(DATA_WIDTH-4){1'b0}}, fun_q};

    // Byte that follows the one currently on TX_P_DATA.
    always_comb begin
        nxt_byte = '0;
        unique case (1'b1)
            (cmd_q == CMD_WR):
                nxt_byte = (idx_n == 2'd1) ? DATA_WIDTH'(addr_q)
                                           : DATA_WIDTH'(opa_q);
            (cmd_q == CMD_RD):
                nxt_byte = DATA_WIDTH'(addr_q);
            (cmd_q == CMD_ALU_OP):
                nxt_byte = (idx_n == 2'd1) ? DATA_WIDTH'(opa_q) :
                           (idx_n == 2'd2) ? DATA_WIDTH'(opb_q) : fun_b;
            (cmd_q == CMD_ALU_NOP):
                nxt_byte = fun_b;
            default:
                nxt_byte = '0;
        endcase
    end

`ifdef CMD_RSP_TIMEOUT_EN
    logic to_run;
    logic to_clr;
    logic to_expired;

    assign to_run = (state == ST_WAIT_LO) || (state == ST_WAIT_HI);
    // Held clear outside the wait states so entry starts from zero.
    assign to_clr = !to_run || RX_D_VLD;

    rsp_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (REF_CLK),
        .rst     (RST),
        .clr     (to_clr),
        .run     (to_run),
        .expired (to_expired)
    );
`endif

    always_ff @(posedge REF_CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            fun_q     <= '0;
            idx_q     <= '0;
            REQ_RDY   <= 1'b1;
            BUSY      <= 1'b0;
            TX_D_VLD  <= 1'b0;
            TX_P_DATA <= '0;
            RSP_DATA  <= '0;
            RSP_VLD   <= 1'b0;
            RSP_ERR   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (REQ_VLD) begin
                        cmd_q    <= REQ_CMD;
                        addr_q   <= REQ_ADDR;
                        opa_q    <= REQ_OPA;
                        opb_q    <= REQ_OPB;
                        fun_q    <= REQ_FUN;
                        idx_q    <= '0;
                        REQ_RDY  <= 1'b0;
                        BUSY     <= 1'b1;
                        RSP_DATA <= '0;
                        RSP_ERR  <= 1'b0;
                        if (is_legal(REQ_CMD)) begin
                            state     <= ST_SEND;
                            TX_D_VLD  <= 1'b1;
                            TX_P_DATA <= DATA_WIDTH'(REQ_CMD);
                        end else begin
                            state   <= ST_DONE;
                            RSP_VLD <= 1'b1;
                            RSP_ERR <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (TX_RDY) begin
                        if (last_byte) begin
                            TX_D_VLD  <= 1'b0;
                            TX_P_DATA <= '0;
                            if (cmd_q == CMD_WR) begin
                                state   <= ST_DONE;
                                RSP_VLD <= 1'b1;
                            end else begin
                                state <= ST_WAIT_LO;
                            end
                        end else begin
                            idx_q     <= idx_n;
                            TX_P_DATA <= nxt_byte;
                        end
                    end
                end
                ST_WAIT_LO: begin
                    if (RX_D_VLD) begin
                        RSP_DATA[DATA_WIDTH-1:0] <= RX_P_DATA;
                        if (rsp_len(cmd_q) == 2'd1) begin
                            state   <= ST_DONE;
                            RSP_VLD <= 1'b1;
                        end else begin
                            state <= ST_WAIT_HI;
                        end
                    end
`ifdef CMD_RSP_TIMEOUT_EN
                    else if (to_expired) begin
                        state   <= ST_DONE;
                        RSP_VLD <= 1'b1;
                        RSP_ERR <= 1'b1;
                    end
`endif
                end
                ST_WAIT_HI: begin
                    if (RX_D_VLD) begin
                        RSP_DATA[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_P_DATA;
                        state   <= ST_DONE;
                        RSP_VLD <= 1'b1;
                    end
`ifdef CMD_RSP_TIMEOUT_EN
                    else if (to_expired) begin
                        state   <= ST_DONE;
                        RSP_VLD <= 1'b1;
                        RSP_ERR <= 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    RSP_VLD <= 1'b0;
                    REQ_RDY <= 1'b1;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: table-driven directed bench for sys_cmd_master,
// plus hand sequences for reset state, mid-frame reset and timeout.
module tb_sys_cmd_master;

    localparam int TO = 16;
`ifdef CMD_RSP_TIMEOUT_EN
    localparam int RD_DLY = 5;
`else
    localparam int RD_DLY = 20;
`endif

    logic        REF_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VLD = 1'b0;
    logic        REQ_RDY;
    logic [7:0]  REQ_CMD = '0;
    logic [3:0]  REQ_ADDR = '0;
    logic [7:0]  REQ_OPA = '0;
    logic [7:0]  REQ_OPB = '0;
    logic [3:0]  REQ_FUN = '0;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_RDY = 1'b1;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_ERR;
    logic        BUSY;

    always #5 REF_CLK = ~REF_CLK;

    sys_cmd_master #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .REF_CLK   (REF_CLK),
        .RST       (RST),
        .REQ_VLD   (REQ_VLD),
        .REQ_RDY   (REQ_RDY),
        .REQ_CMD   (REQ_CMD),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_OPA   (REQ_OPA),
        .REQ_OPB   (REQ_OPB),
        .REQ_FUN   (REQ_FUN),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .TX_RDY    (TX_RDY),
        .RX_P_DATA (RX_P_DATA),
        .RX_D_VLD  (RX_D_VLD),
        .RSP_DATA  (RSP_DATA),
        .RSP_VLD   (RSP_VLD),
        .RSP_ERR   (RSP_ERR),
        .BUSY      (BUSY)
    );

    // tx: first byte in [31:24]; rx: first byte in [15:8].
    typedef struct {
        logic [7:0]  cmd;
        logic [3:0]  addr;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic [3:0]  fun;
        bit          stall;
        bit          rx_last;
        int          rx_dly;
        int          n_rx;
        logic [15:0] rx;
        int          n_tx;
        logic [31:0] tx;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic wait_rdy();
        int g;
        g = 0;
        while (!REQ_RDY && g < 50) begin
            @(negedge REF_CLK);
            g++;
        end
        chk("req_rdy_wait", REQ_RDY, 1);
    endtask

    task automatic drive_req(input vec_t v);
        REQ_VLD  = 1'b1;
        REQ_CMD  = v.cmd;
        REQ_ADDR = v.addr;
        REQ_OPA  = v.opa;
        REQ_OPB  = v.opb;
        REQ_FUN  = v.fun;
        @(negedge REF_CLK);
        REQ_VLD  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int k, nb, st, guard;
        wait_rdy();
        TX_RDY = !v.stall;
        drive_req(v);
        k = 1;
        chk("busy_hi", BUSY, 1);
        chk("req_rdy_lo", REQ_RDY, 0);
        nb = 0;
        st = 0;
        guard = 0;
        while (nb < v.n_tx && guard < 200) begin
            guard++;
            if (!v.stall) chk("tx_vld", TX_D_VLD, 1);
            if (TX_D_VLD) begin
                if (v.stall && st < 3) begin
                    TX_RDY = 1'b0;
                    chk("tx_hold", TX_P_DATA, v.tx[31-8*nb -: 8]);
                    st++;
                end else begin
                    TX_RDY = 1'b1;
                    chk("tx_byte", TX_P_DATA, v.tx[31-8*nb -: 8]);
                    if (v.rx_last && nb == v.n_tx - 1) begin
                        RX_D_VLD  = 1'b1;
                        RX_P_DATA = 8'h99;
                    end
                    nb++;
                    st = 0;
                end
            end
            @(negedge REF_CLK);
            k++;
            RX_D_VLD = 1'b0;
            if (v.stall) TX_RDY = 1'b0;
        end
        TX_RDY = 1'b1;
        chk("tx_count", nb, v.n_tx);
        chk("tx_vld_off", TX_D_VLD, 0);
        if (v.n_rx == 0) begin
            chk("rsp_vld", RSP_VLD, 1);
            if (!v.stall) chk("rsp_lat", k, v.n_tx + 1);
        end else begin
            chk("no_early_rsp", RSP_VLD, 0);
            repeat (v.rx_dly) @(negedge REF_CLK);
            for (int i = 0; i < v.n_rx; i++) begin
                RX_D_VLD  = 1'b1;
                RX_P_DATA = v.rx[15-8*i -: 8];
                @(negedge REF_CLK);
                RX_D_VLD  = 1'b0;
                if (i < v.n_rx - 1) begin
                    chk("no_mid_rsp", RSP_VLD, 0);
                    @(negedge REF_CLK);
                end
            end
            chk("rsp_vld", RSP_VLD, 1);
        end
        chk("rsp_data", RSP_DATA, v.exp_data);
        chk("rsp_err", RSP_ERR, v.exp_err);
        @(negedge REF_CLK);
        chk("rsp_pulse", RSP_VLD, 0);
        chk("rdy_back", REQ_RDY, 1);
        chk("busy_lo", BUSY, 0);
        chk("rsp_hold", RSP_DATA, v.exp_data);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"}, REQ_RDY, 1);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_txv"}, TX_D_VLD, 0);
        chk({tag, "_txd"}, TX_P_DATA, 0);
        chk({tag, "_rspd"}, RSP_DATA, 0);
        chk({tag, "_rspv"}, RSP_VLD, 0);
        chk({tag, "_rspe"}, RSP_ERR, 0);
    endtask

    initial begin
        vec_t dd;
        vecs[0] = '{cmd:8'hAA, addr:4'h5, opa:8'h3C, opb:8'h00, fun:4'h0,
                    stall:0, rx_last:0, rx_dly:0, n_rx:0, rx:16'h0,
                    n_tx:3, tx:32'hAA053C00, exp_data:16'h0000, exp_err:0};
        vecs[1] = '{cmd:8'hBB, addr:4'h2, opa:8'h00, opb:8'h00, fun:4'h0,
                    stall:0, rx_last:0, rx_dly:RD_DLY, n_rx:1, rx:16'h7E00,
                    n_tx:2, tx:32'hBB020000, exp_data:16'h007E, exp_err:0};
        vecs[2] = '{cmd:8'hCC, addr:4'h0, opa:8'h10, opb:8'h20, fun:4'h0,
                    stall:1, rx_last:0, rx_dly:2, n_rx:2, rx:16'h3000,
                    n_tx:4, tx:32'hCC102000, exp_data:16'h0030, exp_err:0};
        vecs[3] = '{cmd:8'h55, addr:4'h3, opa:8'h11, opb:8'h22, fun:4'h1,
                    stall:0, rx_last:0, rx_dly:0, n_rx:0, rx:16'h0,
                    n_tx:0, tx:32'h0, exp_data:16'h0000, exp_err:1};
        vecs[4] = '{cmd:8'hDD, addr:4'h0, opa:8'h00, opb:8'h00, fun:4'h1,
                    stall:0, rx_last:1, rx_dly:3, n_rx:2, rx:16'h3412,
                    n_tx:2, tx:32'hDD010000, exp_data:16'h1234, exp_err:0};
        vecs[5] = '{cmd:8'hCC, addr:4'h0, opa:8'hFF, opb:8'h01, fun:4'hF,
                    stall:0, rx_last:0, rx_dly:1, n_rx:2, rx:16'h5AA5,
                    n_tx:4, tx:32'hCCFF010F, exp_data:16'hA55A, exp_err:0};
        vecs[6] = '{cmd:8'hBB, addr:4'hF, opa:8'h00, opb:8'h00, fun:4'h0,
                    stall:0, rx_last:1, rx_dly:0, n_rx:1, rx:16'hC300,
                    n_tx:2, tx:32'hBB0F0000, exp_data:16'h00C3, exp_err:0};

        repeat (3) @(negedge REF_CLK);
        chk_reset_outs("rst");
        RST = 1'b0;
        // Stray RX while idle must not disturb anything.
        RX_D_VLD  = 1'b1;
        RX_P_DATA = 8'hEE;
        @(negedge REF_CLK);
        RX_D_VLD  = 1'b0;
        chk_reset_outs("stray");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // DD request, reset after its first byte has transferred.
        dd = vecs[4];
        wait_rdy();
        TX_RDY = 1'b1;
        drive_req(dd);
        chk("dd_b0", TX_P_DATA, 8'hDD);
        @(negedge REF_CLK);
        chk("dd_b1", TX_P_DATA, 8'h01);
        RST = 1'b1;
        #1;
        chk_reset_outs("midrst");
        @(negedge REF_CLK);
        RST = 1'b0;
        run_vec(vecs[0]);

`ifdef CMD_RSP_TIMEOUT_EN
        begin
            vec_t tv;
            int g, j;
            tv = vecs[5];
            wait_rdy();
            TX_RDY = 1'b1;
            drive_req(tv);
            g = 0;
            while (TX_D_VLD && g < 20) begin
                @(negedge REF_CLK);
                g++;
            end
            chk("to_tx_done", TX_D_VLD, 0);
            repeat (3) @(negedge REF_CLK);
            RX_D_VLD  = 1'b1;
            RX_P_DATA = 8'hAB;
            @(negedge REF_CLK);
            RX_D_VLD  = 1'b0;
            j = 1;
            while (!RSP_VLD && j < 40) begin
                @(negedge REF_CLK);
                j++;
            end
            chk("to_vld", RSP_VLD, 1);
            chk("to_lat", (j >= TO && j <= TO + 1), 1);
            chk("to_err", RSP_ERR, 1);
            chk("to_data", RSP_DATA, 16'h00AB);
            @(negedge REF_CLK);
            chk("to_rdy", REQ_RDY, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
